s_axis_win_rx: RTL and testbench
================================

Name: s_axis_win_rx

Overview:
- Parametrised AXI4-Stream pixel receiver and sliding-window packer.
- Accepts one pixel per 32-bit beat from the DMA MM2S stream.
- Builds a horizontal window of WIN consecutive pixels per line and emits one WIN-pixel word per accepted beat once the window is full.
- Adds downstream backpressure, line tracking and error flags for the conv/filter datapath.

Parameters:
- DATA_W, 32, s_axis_tdata width; must be ≥ PIX_W.
- PIX_W, 24, pixel width taken from tdata[PIX_W-1:0].
- CH, 3, channels per pixel; PIX_W must be divisible by CH.
- WIN, 3, window length in pixels; must be ≥ 2.
- LINE_W, 960, nominal pixels per line.
- CNT_W, 10, pixel counter width; must satisfy 2^CNT_W > LINE_W.
- LCNT_W, 10, line counter width.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- s_axis_tready, out, 1, slave ready.
- s_axis_tdata, in, DATA_W, pixel beat.
- s_axis_tstrb, in, DATA_W/8, ignored.
- s_axis_tlast, in, 1, end of line from DMA.
- s_axis_tvalid, in, 1, beat valid.
- out_data, out, WIN*PIX_W, window word; oldest pixel in the MSBs.
- out_valid, out, 1, window word valid.
- out_ready, in, 1, downstream ready.
- out_last, out, 1, last window word of the line.
- line_cnt, out, LCNT_W, completed lines; wraps.
- err_early, out, 1, sticky: tlast arrived before LINE_W pixels.
- err_nolast, out, 1, sticky: LINE_W pixels arrived without tlast.
- err_short, out, 1, sticky: line ended with fewer than WIN pixels.
- err_clr, in, 1, clears all sticky error flags.

Behaviour:
- Reset (async assert, sync deassert assumed upstream). All outputs are 0, window is 0, pix_cnt is 0, state is FILL.
- Accept: acc = s_axis_tvalid & s_axis_tready.
- s_axis_tready = 1 in FILL; (!out_valid | out_ready) in STREAM.
- Window register: on every acc, shifts left by PIX_W and inserts tdata[PIX_W-1:0] at the LSBs.
- pix_cnt: increments on acc. Resets to 0 on the line-end beat.
- Line-end beat: acc & (s_axis_tlast | pix_cnt == LINE_W-1). The line ends at whichever condition occurs first.
- FSM FILL:
  - Collects the first WIN-1 pixels of a line.
  - Transitions to STREAM when acc & pix_cnt == WIN-2 and the beat is not a line end.
  - A line end in FILL returns to FILL with pix_cnt = 0, sets err_short and increments line_cnt. No output is produced.
- FSM STREAM:
  - Each acc loads out_data = {window[(WIN-1)*PIX_W-1:0], new pixel} and sets out_valid = 1 in the same edge. Latency is 1 clk from acc.
  - On the line-end beat, out_last is loaded as 1, line_cnt increments and the state returns to FILL.
- Output handshake:
  - out_valid/out_data/out_last hold until out_ready.
  - out_valid clears on out_ready unless a new acc loads the register in the same cycle.
  - While the last word of a line is stalled, FILL beats of the next line are still accepted; the output register is untouched.
- Error flags:
  - err_early is set when tlast arrives with pix_cnt < LINE_W-1.
  - err_nolast is set when pix_cnt == LINE_W-1 without tlast.
  - Flags are sticky. err_clr clears them; a set event in the same cycle wins.
- Words per line = n - (WIN-1), where n = min(pixels to tlast, LINE_W).
- A tlast-free overrun continues counting into the next line.
- A mid-line reset discards the window. After reset, the next beat starts a fresh line.

Optional Feature:
- Macro: PLANAR_OUT_EN.
- Defined: out_data is channel-major. For each channel c (MSB channel first), the WIN samples of that channel are placed oldest→newest. With PIX_W=24, CH=3, WIN=3 this gives {R0,R1,R2,G0,G1,G2,B0,B1,B2}. This is a pure combinational reorder of the registered word; timing is unchanged.
- Undefined: pixel-major order as described in Behaviour.

Decomposition:
- Package s_axis_win_pkg holds:
  - state enum (FILL, STREAM);
  - function planar_reorder(word, PIX_W, CH, WIN);
  - default parameter constants.
- Sub-module pixel_window_shift: WIN*PIX_W shift register with enable and synchronous line clear.

Test Plan (WIN=3, LINE_W=8, PIX_W=24):
- Normal line: beats 0x01..0x08, tlast on the 8th, out_ready=1 → 6 words; first word {0x01,0x02,0x03}; out_last only on {0x06,0x07,0x08}; line_cnt=1; no errors.
- Backpressure: out_ready low for 4 cycles mid-line → out_data held stable, s_axis_tready=0 in STREAM, no pixel lost; word sequence identical to the normal-line case.
- Early tlast: tlast on the 5th beat → 3 words, out_last on {0x03,0x04,0x05}, err_early=1; err_clr pulse → 0.
- Missing tlast: 10 beats, no tlast → line ends at beat 8 with out_last; beats 9–10 start a new line in FILL; err_nolast=1; line_cnt=1.
- Short line: tlast on the 2nd beat → no output, err_short=1, err_early=1, line_cnt=1.
- Async reset asserted mid-STREAM → all outputs 0 immediately; the next line produces a first word from fresh pixels only. With PLANAR_OUT_EN, pixels 0xAABBCC, 0xDDEEFF, 0x112233 → out_data = 0xAADD11_BBEE22_CCFF33.

Source files
------------

// File: rtl/s_axis_win_rx_pkg.sv
// Shared state type, default parameters and the planar reorder helper for s_axis_win_rx.
// The planar reorder is only used when PLANAR_OUT_EN is defined.
package s_axis_win_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PIX_W  = 24;
  localparam int DEF_CH     = 3;
  localparam int DEF_WIN    = 3;
  localparam int DEF_LINE_W = 960;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_LCNT_W = 10;

  localparam int MAX_WORD_W = 1024;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Pixel-major word (oldest pixel in the MSBs) -> channel-major word,
  // MSB channel first, each channel's samples ordered oldest to newest.
  function automatic logic [MAX_WORD_W-1:0] planar_reorder(
    input logic [MAX_WORD_W-1:0] word,
    input int                    pix_w,
    input int                    ch,
    input int                    win
  );
    logic [MAX_WORD_W-1:0] res;
    int sw;
    int src;
    int dst;
    res = '0;
    sw  = pix_w / ch;
    for (int p = 0; p < win; p++) begin
      for (int c = 0; c < ch; c++) begin
        for (int b = 0; b < sw; b++) begin
          src = (win - 1 - p) * pix_w + (ch - 1 - c) * sw + b;
          dst = (ch - 1 - c) * win * sw + (win - 1 - p) * sw + b;
          res[dst] = word[src];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/s_axis_win_rx_if.sv
// AXI4-Stream beat bundle carrying the DMA MM2S pixel stream into s_axis_win_rx.
interface s_axis_win_rx_if
  import s_axis_win_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tstrb, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/s_axis_win_rx_pixel_window_shift.sv
// WIN-pixel shift register: new pixels enter at the LSBs, oldest sits in the MSBs.
// A synchronous clear empties the window at each line end; clear beats enable.
module pixel_window_shift
  import s_axis_win_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int WIN   = DEF_WIN
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [PIX_W-1:0]     pix_i,
  output logic [WIN*PIX_W-1:0] win_o
);

  logic [WIN*PIX_W-1:0] win_q;
  logic [WIN*PIX_W-1:0] win_d;

  always_comb begin
    win_d = win_q;
    if (clr_i) begin
      win_d = '0;
    end else if (en_i) begin
      win_d = {win_q[(WIN-1)*PIX_W-1:0], pix_i};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/s_axis_win_rx.sv
// AXI4-Stream pixel receiver that emits one WIN-pixel sliding-window word per accepted beat.
// Define PLANAR_OUT_EN to present out_data channel-major instead of pixel-major.
module s_axis_win_rx
  import s_axis_win_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int CH     = DEF_CH,
  parameter int WIN    = DEF_WIN,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LCNT_W = DEF_LCNT_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  s_axis_win_rx_if.slave       s_axis,
  output logic [WIN*PIX_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [LCNT_W-1:0]    line_cnt,
  output logic                 err_early,
  output logic                 err_nolast,
  output logic                 err_short,
  input  logic                 err_clr
);

  localparam int OUT_W  = WIN * PIX_W;
  localparam int KEEP_W = (WIN - 1) * PIX_W;

  if ((PIX_W % CH) != 0 || DATA_W < PIX_W || WIN < 2 || (2 ** CNT_W) <= LINE_W) begin : gParamCheck
    $error("s_axis_win_rx: illegal parameter combination");
  end

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    pixCnt_q,   pixCnt_d;
  logic [LCNT_W-1:0]   lineCnt_q,  lineCnt_d;
  logic [OUT_W-1:0]    outData_q,  outData_d;
  logic                outValid_q, outValid_d;
  logic                outLast_q,  outLast_d;
  logic                errEarly_q, errEarly_d;
  logic                errNolast_q, errNolast_d;
  logic                errShort_q, errShort_d;

  logic [OUT_W-1:0]    window;
  logic [PIX_W-1:0]    pix;
  logic                acc;
  logic                atLineMax;
  logic                lineEnd;
  logic                unusedBits;

  assign pix           = s_axis.tdata[PIX_W-1:0];
  assign s_axis.tready = (state_q == FILL) | ~outValid_q | out_ready;
  assign acc           = s_axis.tvalid & s_axis.tready;
  assign atLineMax     = (pixCnt_q == CNT_W'(LINE_W - 1));
  assign lineEnd       = acc & (s_axis.tlast | atLineMax);
  assign unusedBits    = ^{s_axis.tstrb, s_axis.tdata, window[OUT_W-1:KEEP_W]};

  pixel_window_shift #(
    .PIX_W (PIX_W),
    .WIN   (WIN)
  ) uWindow (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (acc),
    .clr_i (lineEnd),
    .pix_i (pix),
    .win_o (window)
  );

  always_comb begin
    state_d     = state_q;
    pixCnt_d    = pixCnt_q;
    lineCnt_d   = lineCnt_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    errEarly_d  = errEarly_q & ~err_clr;
    errNolast_d = errNolast_q & ~err_clr;
    errShort_d  = errShort_q & ~err_clr;

    if (acc) begin
      pixCnt_d = lineEnd ? '0 : pixCnt_q + CNT_W'(1);
    end
    if (lineEnd) begin
      lineCnt_d = lineCnt_q + LCNT_W'(1);
    end
    if (acc && s_axis.tlast && (pixCnt_q < CNT_W'(LINE_W - 1))) begin
      errEarly_d = 1'b1;
    end
    if (acc && atLineMax && !s_axis.tlast) begin
      errNolast_d = 1'b1;
    end

    // A consumed word drops out unless a new beat reloads the register below.
    if (out_ready) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (lineEnd) begin
          errShort_d = 1'b1;
        end else if (acc && (pixCnt_q == CNT_W'(WIN - 2))) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (acc) begin
          outData_d  = {window[KEEP_W-1:0], pix};
          outValid_d = 1'b1;
          outLast_d  = lineEnd;
          if (lineEnd) begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      pixCnt_q    <= '0;
      lineCnt_q   <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      errEarly_q  <= 1'b0;
      errNolast_q <= 1'b0;
      errShort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixCnt_q    <= pixCnt_d;
      lineCnt_q   <= lineCnt_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      errEarly_q  <= errEarly_d;
      errNolast_q <= errNolast_d;
      errShort_q  <= errShort_d;
    end
  end

`ifdef PLANAR_OUT_EN
  assign out_data = OUT_W'(planar_reorder(MAX_WORD_W'(outData_q), PIX_W, CH, WIN));
`else
  assign out_data = outData_q;
`endif

  assign out_valid  = outValid_q;
  assign out_last   = outLast_q;
  assign line_cnt   = lineCnt_q;
  assign err_early  = errEarly_q;
  assign err_nolast = errNolast_q;
  assign err_short  = errShort_q;

endmodule

// File: tb/tb_s_axis_win_rx.sv
// Bench for s_axis_win_rx (WIN=3, LINE_W=8): line-level model checked every cycle plus literal pins.
// Honours PLANAR_OUT_EN when building expected words.
module tb_s_axis_win_rx;

  localparam int DATA_W = 32;
  localparam int PIX_W  = 24;
  localparam int CH     = 3;
  localparam int WIN    = 3;
  localparam int LINE_W = 8;
  localparam int CNT_W  = 10;
  localparam int LCNT_W = 10;
  localparam int OUT_W  = WIN * PIX_W;
  localparam int SW     = PIX_W / CH;

`ifdef PLANAR_OUT_EN
  localparam logic [OUT_W-1:0] LIT_123   = 72'h000000_000000_010203;
  localparam logic [OUT_W-1:0] LIT_345   = 72'h000000_000000_030405;
  localparam logic [OUT_W-1:0] LIT_678   = 72'h000000_000000_060708;
  localparam logic [OUT_W-1:0] LIT_FRESH = 72'hAADD11_BBEE22_CCFF33;
`else
  localparam logic [OUT_W-1:0] LIT_123   = 72'h000001_000002_000003;
  localparam logic [OUT_W-1:0] LIT_345   = 72'h000003_000004_000005;
  localparam logic [OUT_W-1:0] LIT_678   = 72'h000006_000007_000008;
  localparam logic [OUT_W-1:0] LIT_FRESH = 72'hAABBCC_DDEEFF_112233;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } word_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              out_ready;
  logic              err_clr;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_last;
  logic [LCNT_W-1:0] line_cnt;
  logic              err_early;
  logic              err_nolast;
  logic              err_short;

  int vectors = 0;
  int miscompares = 0;

  logic [PIX_W-1:0] winPix[$];
  word_t            expWords[$];
  word_t            gotLog[$];
  int               lineN = 0;
  int               expLineCnt = 0;
  logic             expEarly = 1'b0;
  logic             expNolast = 1'b0;
  logic             expShort = 1'b0;
  int               stallSeen = 0;

  always #5 clk = ~clk;

  s_axis_win_rx_if #(.DATA_W(DATA_W)) s_axis ();

  s_axis_win_rx #(
    .DATA_W (DATA_W),
    .PIX_W  (PIX_W),
    .CH     (CH),
    .WIN    (WIN),
    .LINE_W (LINE_W),
    .CNT_W  (CNT_W),
    .LCNT_W (LCNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_axis     (s_axis),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .line_cnt   (line_cnt),
    .err_early  (err_early),
    .err_nolast (err_nolast),
    .err_short  (err_short),
    .err_clr    (err_clr)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Builds the expected output word from the three most recent pixels of the line.
  function automatic logic [OUT_W-1:0] makeWord(input logic [PIX_W-1:0] p0,
                                                input logic [PIX_W-1:0] p1,
                                                input logic [PIX_W-1:0] p2);
    logic [OUT_W-1:0] w;
`ifdef PLANAR_OUT_EN
    logic [PIX_W-1:0] px[3];
    px[0] = p0;
    px[1] = p1;
    px[2] = p2;
    w = '0;
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < WIN; p++) begin
        w[OUT_W-1-(c*WIN+p)*SW -: SW] = px[p][PIX_W-1-c*SW -: SW];
      end
    end
`else
    w = {p0, p1, p2};
`endif
    return w;
  endfunction

  task automatic modelBeat(input logic [PIX_W-1:0] px, input logic isLast);
    logic lineEndNow;
    lineN++;
    winPix.push_back(px);
    if (winPix.size() > WIN) void'(winPix.pop_front());
    lineEndNow = isLast || (lineN == LINE_W);
    if (lineN >= WIN) expWords.push_back('{data: makeWord(winPix[0], winPix[1], winPix[2]), last: lineEndNow});
    if (isLast && lineN < LINE_W) expEarly = 1'b1;
    if (!isLast && lineN == LINE_W) expNolast = 1'b1;
    if (lineEndNow) begin
      if (lineN < WIN) expShort = 1'b1;
      expLineCnt++;
      lineN = 0;
      winPix.delete();
    end
  endtask

  // Compare process: check against the model, then advance it for the coming edge.
  always @(negedge clk) begin
    if (!rstn) begin
      winPix.delete();
      expWords.delete();
      lineN = 0;
      expLineCnt = 0;
      expEarly = 1'b0;
      expNolast = 1'b0;
      expShort = 1'b0;
    end else begin
      checkOutput("out_valid", 128'(out_valid), 128'(expWords.size() > 0));
      if (expWords.size() > 0) begin
        checkOutput("out_data", 128'(out_data), 128'(expWords[0].data));
        checkOutput("out_last", 128'(out_last), 128'(expWords[0].last));
      end
      checkOutput("tready", 128'(s_axis.tready),
                  128'((lineN < WIN - 1) || (expWords.size() == 0) || out_ready));
      if (!s_axis.tready) stallSeen++;
      checkOutput("line_cnt", 128'(line_cnt), 128'(LCNT_W'(expLineCnt)));
      checkOutput("err_early", 128'(err_early), 128'(expEarly));
      checkOutput("err_nolast", 128'(err_nolast), 128'(expNolast));
      checkOutput("err_short", 128'(err_short), 128'(expShort));

      if (out_valid && out_ready) gotLog.push_back('{data: out_data, last: out_last});
      if (expWords.size() > 0 && out_ready) void'(expWords.pop_front());
      if (err_clr) begin
        expEarly = 1'b0;
        expNolast = 1'b0;
        expShort = 1'b0;
      end
      if (s_axis.tvalid && s_axis.tready) modelBeat(s_axis.tdata[PIX_W-1:0], s_axis.tlast);
    end
  end

  // Entered and left at posedge+1; holds the beat until the DUT takes it.
  task automatic applyStimulus(input logic [PIX_W-1:0] px, input logic isLast);
    bit taken;
    taken = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = {8'hA5, px};
    s_axis.tstrb  = 4'hF;
    s_axis.tlast  = isLast;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge clk);
      taken = s_axis.tready;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL tready_timeout: beat %0h not accepted within 40 cycles", px);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, "_out_data"}, 128'(out_data), 128'(0));
    checkOutput({tag, "_out_last"}, 128'(out_last), 128'(0));
    checkOutput({tag, "_line_cnt"}, 128'(line_cnt), 128'(0));
    checkOutput({tag, "_errs"}, 128'({err_early, err_nolast, err_short}), 128'(0));
  endtask

  task automatic resetDut(input string tag);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkZeroOutputs(tag);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    gotLog.delete();
  endtask

  task automatic checkLog(input string name, input int idx, input logic [OUT_W-1:0] expData, input logic expLast);
    if (idx >= gotLog.size()) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got %0d logged words, expected index %0d to exist", name, gotLog.size(), idx);
    end else begin
      checkOutput({name, "_data"}, 128'(gotLog[idx].data), 128'(expData));
      checkOutput({name, "_last"}, 128'(gotLog[idx].last), 128'(expLast));
    end
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tstrb  = '0;
    s_axis.tlast  = 1'b0;
    out_ready     = 1'b1;
    err_clr       = 1'b0;
    #1 rstn = 1'b0;
    #1 checkZeroOutputs("por");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Normal line
    for (int i = 1; i <= 8; i++) applyStimulus(PIX_W'(i), i == 8);
    idle(4);
    checkOutput("n1_words", 128'(gotLog.size()), 128'(6));
    checkLog("n1_first", 0, LIT_123, 1'b0);
    checkLog("n1_fifth", 4, makeWord(24'h5, 24'h6, 24'h7), 1'b0);
    checkLog("n1_final", 5, LIT_678, 1'b1);
    checkOutput("n1_line_cnt", 128'(line_cnt), 128'(1));
    gotLog.delete();

    // Backpressure mid-line
    stallSeen = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) applyStimulus(PIX_W'(i), i == 8);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);
    checkOutput("bp_stalled", 128'(stallSeen > 0), 128'(1));
    checkOutput("bp_words", 128'(gotLog.size()), 128'(6));
    checkLog("bp_first", 0, LIT_123, 1'b0);
    checkLog("bp_final", 5, LIT_678, 1'b1);
    gotLog.delete();

    // Early tlast, then clear
    for (int i = 1; i <= 5; i++) applyStimulus(PIX_W'(i), i == 5);
    idle(3);
    checkOutput("early_words", 128'(gotLog.size()), 128'(3));
    checkLog("early_final", 2, LIT_345, 1'b1);
    checkOutput("early_flag", 128'(err_early), 128'(1));
    checkOutput("early_line_cnt", 128'(line_cnt), 128'(3));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    checkOutput("early_cleared", 128'(err_early), 128'(0));

    // Missing tlast
    resetDut("rst_a");
    for (int i = 1; i <= 10; i++) applyStimulus(PIX_W'(i), 1'b0);
    idle(3);
    checkOutput("nolast_words", 128'(gotLog.size()), 128'(6));
    checkLog("nolast_final", 5, LIT_678, 1'b1);
    checkOutput("nolast_flags", 128'({err_early, err_nolast, err_short}), 128'(3'b010));
    checkOutput("nolast_line_cnt", 128'(line_cnt), 128'(1));

    // Short line
    resetDut("rst_b");
    applyStimulus(24'h1, 1'b0);
    applyStimulus(24'h2, 1'b1);
    idle(3);
    checkOutput("short_words", 128'(gotLog.size()), 128'(0));
    checkOutput("short_flags", 128'({err_early, err_nolast, err_short}), 128'(3'b101));
    checkOutput("short_line_cnt", 128'(line_cnt), 128'(1));

    // Async reset mid-STREAM, then a fresh line
    resetDut("rst_c");
    for (int i = 1; i <= 5; i++) applyStimulus(PIX_W'(8'h20 + i), 1'b0);
    resetDut("rst_mid");
    applyStimulus(24'hAABBCC, 1'b0);
    applyStimulus(24'hDDEEFF, 1'b0);
    applyStimulus(24'h112233, 1'b0);
    applyStimulus(24'h445566, 1'b1);
    idle(3);
    checkOutput("fresh_words", 128'(gotLog.size()), 128'(2));
    checkLog("fresh_first", 0, LIT_FRESH, 1'b0);
    checkLog("fresh_final", 1, makeWord(24'hDDEEFF, 24'h112233, 24'h445566), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
